bus_demux_1x4: RTL and testbench

- Routes one initiator bus request to one of four memory-mapped targets and returns the selected target's response to the initiator. It is the distribution-side counterpart of the 4:1 read-data selection in the processor datapath.
- Sits between the core's data-memory port and the SoC targets: RAM, GPIO, UART and timer.
- One outstanding transaction at a time.
- Unresponsive or disabled targets are converted into error responses, so the core never hangs.

---
 rtl/bus_demux_1x4_pkg.sv | 30 +++
 rtl/bus_demux_1x4_timeout_ctr.sv | 41 ++++
 rtl/bus_demux_1x4.sv | 201 ++++++++++++++++++++
 tb/tb_bus_demux_1x4.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_demux_1x4_pkg.sv
// Shared definitions for the 1:4 initiator-to-target bus demultiplexer:
// bus widths, default parameters, FSM state encoding and a select helper.
package bus_demux_1x4_pkg;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int BE_W            = 4;
    localparam int N_TGT           = 4;
    localparam int SEL_W           = 2;
    localparam int CNT_W           = 16;
    localparam int DEFAULT_SEL_LSB = 28;
    localparam int DEFAULT_TIMEOUT = 255;

    localparam logic [N_TGT-1:0] DEFAULT_TARGET_EN = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [N_TGT-1:0] tgt_onehot(input logic [SEL_W-1:0] sel);
        logic [N_TGT-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_demux_1x4_timeout_ctr.sv
// Transaction watchdog: counts cycles spent waiting on a target and flags the
// cycle that is the terminal-th one, so the caller can force an error response.
module bus_demux_1x4_timeout_ctr
    import bus_demux_1x4_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] terminal,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W:0]   count_inc;

    // count_q holds the cycles already completed, so the current cycle is count_q+1.
    assign count_inc = {1'b0, count_q} + {{W{1'b0}}, 1'b1};
    assign expired   = en && (count_inc == {1'b0, terminal});

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !count_inc[W]) begin
            count_d = count_inc[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bus_demux_1x4.sv
// Routes one initiator request to one of four targets selected by two address
// bits and returns that target's response; silent or missing targets yield errors.
module bus_demux_1x4
    import bus_demux_1x4_pkg::*;
#(
    parameter int               SEL_LSB   = DEFAULT_SEL_LSB,
    parameter logic [N_TGT-1:0] TARGET_EN = DEFAULT_TARGET_EN,
    parameter int               TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    input  logic                    req_we,
    input  logic [BE_W-1:0]         req_be,

    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,

    output logic [N_TGT-1:0]        t_req_valid,
    input  logic [N_TGT-1:0]        t_req_ready,
    output logic [ADDR_W-1:0]       t_req_addr,
    output logic [DATA_W-1:0]       t_req_wdata,
    output logic                    t_req_we,
    output logic [BE_W-1:0]         t_req_be,

    input  logic [N_TGT-1:0]        t_rsp_valid,
    input  logic [N_TGT*DATA_W-1:0] t_rsp_rdata,
    input  logic [N_TGT-1:0]        t_rsp_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_e             state_q;
    state_e             state_d;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  wdata_d;
    logic               we_q;
    logic               we_d;
    logic [BE_W-1:0]    be_q;
    logic [BE_W-1:0]    be_d;
    logic [N_TGT-1:0]   t_req_valid_q;
    logic [N_TGT-1:0]   t_req_valid_d;
    logic               rsp_valid_q;
    logic               rsp_valid_d;
    logic               rsp_err_q;
    logic               rsp_err_d;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic [DATA_W-1:0]  rsp_rdata_d;

    logic [SEL_W-1:0]   req_sel;
    logic               accept;
    logic               cnt_en;
    logic               expired;
    logic               sel_ready;
    logic               sel_rsp;
    logic               take_rsp;
    logic               force_err;
    logic [DATA_W-1:0]  rsp_slice [N_TGT];

    generate
        for (genvar gi = 0; gi < N_TGT; gi++) begin : g_rsp_slice
            assign rsp_slice[gi] = t_rsp_rdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Higher address bits are ignored, so the target map aliases across the space.
    assign req_sel   = req_addr[SEL_LSB+1:SEL_LSB];
    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign cnt_en    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign sel_ready = t_req_ready[sel_q];
    assign sel_rsp   = t_rsp_valid[sel_q];

    bus_demux_1x4_timeout_ctr #(
        .W        (CNT_W)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .en       (cnt_en),
        .terminal (TIMEOUT_CNT),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            be_q          <= '0;
            t_req_valid_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            be_q          <= be_d;
            t_req_valid_q <= t_req_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    // A captured response always beats the watchdog in the same cycle.
    always_comb begin
        state_d   = state_q;
        take_rsp  = 1'b0;
        force_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!TARGET_EN[req_sel]) begin
                        state_d   = ST_RESP;
                        force_err = 1'b1;
                    end else begin
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (sel_ready && sel_rsp) begin
                    state_d  = ST_RESP;
                    take_rsp = 1'b1;
                end else if (expired) begin
                    state_d   = ST_RESP;
                    force_err = 1'b1;
                end else if (sel_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sel_rsp) begin
                    state_d  = ST_RESP;
                    take_rsp = 1'b1;
                end else if (expired) begin
                    state_d   = ST_RESP;
                    force_err = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        be_d    = be_q;
        if (accept) begin
            sel_d   = req_sel;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            we_d    = req_we;
            be_d    = req_be;
        end

        t_req_valid_d = (state_d == ST_ISSUE) ? tgt_onehot(sel_d) : '0;
        rsp_valid_d   = (state_d == ST_RESP);

        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (take_rsp) begin
            rsp_rdata_d = we_q ? '0 : rsp_slice[sel_q];
            rsp_err_d   = t_rsp_err[sel_q];
        end else if (force_err) begin
            rsp_err_d   = 1'b1;
        end
    end

    assign t_req_valid = t_req_valid_q;
    assign t_req_addr  = addr_q;
    assign t_req_wdata = wdata_q;
    assign t_req_we    = we_q;
    assign t_req_be    = be_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_bus_demux_1x4.sv
// Self-checking bench for bus_demux_1x4: directed scenarios plus randomized
// transactions, each predicted by cycle arithmetic from the bus rules.
module tb_bus_demux_1x4;

    localparam int         TMO    = 8;
    localparam logic [3:0] TGT_EN = 4'b0111;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         req_we;
    logic [3:0]   req_be;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [3:0]   t_req_valid;
    logic [3:0]   t_req_ready;
    logic [31:0]  t_req_addr;
    logic [31:0]  t_req_wdata;
    logic         t_req_we;
    logic [3:0]   t_req_be;
    logic [3:0]   t_rsp_valid;
    logic [127:0] t_rsp_rdata;
    logic [3:0]   t_rsp_err;

    int n_checks;
    int n_errors;

    bus_demux_1x4 #(
        .SEL_LSB   (28),
        .TARGET_EN (TGT_EN),
        .TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_we      (req_we),
        .req_be      (req_be),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .t_req_valid (t_req_valid),
        .t_req_ready (t_req_ready),
        .t_req_addr  (t_req_addr),
        .t_req_wdata (t_req_wdata),
        .t_req_we    (t_req_we),
        .t_req_be    (t_req_be),
        .t_rsp_valid (t_rsp_valid),
        .t_rsp_rdata (t_rsp_rdata),
        .t_rsp_err   (t_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // r: cycles the target waits in ISSUE before accepting; d: cycles from accept
    // to response (0 = same cycle). Cycle 0 is the accept cycle.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] be, input int r, input int d,
                           input logic [31:0] data, input logic err, input bit noisy);
        int          sel;
        logic [3:0]  oh;
        bit          en;
        int          ready_cyc;
        int          rsp_cyc;
        int          exp_cyc;
        int          issue_last;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [3:0]  exp_tv;

        sel       = int'(addr[29:28]);
        oh        = 4'b0001 << sel;
        en        = TGT_EN[sel];
        ready_cyc = 1 + r;
        rsp_cyc   = 1 + r + d;
        if (!en) begin
            exp_cyc    = 1;
            exp_rd     = 32'h0;
            exp_err    = 1'b1;
            issue_last = 0;
        end else begin
            issue_last = (ready_cyc < TMO) ? ready_cyc : TMO;
            if (rsp_cyc <= TMO) begin
                exp_cyc = rsp_cyc + 1;
                exp_rd  = we ? 32'h0 : data;
                exp_err = err;
            end else begin
                exp_cyc = TMO + 1;
                exp_rd  = 32'h0;
                exp_err = 1'b1;
            end
        end

        for (int k = 0; k <= exp_cyc + 2; k++) begin
            @(posedge clk);
            #1;
            req_valid   = (k == 0);
            req_addr    = addr;
            req_wdata   = wdata;
            req_we      = we;
            req_be      = be;
            t_req_ready = 4'($urandom_range(15, 0)) & ~oh;
            t_rsp_valid = (noisy ? 4'hF : 4'($urandom_range(15, 0))) & ~oh;
            t_rsp_err   = 4'($urandom_range(15, 0));
            t_rsp_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (en && k == ready_cyc) t_req_ready[sel] = 1'b1;
            if (en && k == rsp_cyc) begin
                t_rsp_valid[sel]            = 1'b1;
                t_rsp_rdata[sel*32 +: 32]   = data;
                t_rsp_err[sel]              = err;
            end
            @(negedge clk);
            check_eq("req_ready", 32'(req_ready), 32'((k == 0) || (k > exp_cyc)));
            check_eq("rsp_valid", 32'(rsp_valid), 32'(k == exp_cyc));
            if (k == exp_cyc) begin
                check_eq("rsp_rdata", rsp_rdata, exp_rd);
                check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
            exp_tv = (k >= 1 && k <= issue_last) ? oh : 4'b0000;
            check_eq("t_req_valid", 32'(t_req_valid), 32'(exp_tv));
            if (k >= 1 && k <= issue_last) begin
                check_eq("t_req_addr", t_req_addr, addr);
                check_eq("t_req_wdata", t_req_wdata, wdata);
                check_eq("t_req_we", 32'(t_req_we), 32'(we));
                check_eq("t_req_be", 32'(t_req_be), 32'(be));
            end
        end
        $display("TXN addr=%h we=%0d tgt=%0d r=%0d d=%0d exp_cycle=%0d exp_err=%0d exp_rdata=%h errors_so_far=%0d",
                 addr, we, sel, r, d, exp_cyc, exp_err, exp_rd, n_errors);
    endtask

    task automatic idle_targets();
        t_req_ready = 4'h0;
        t_rsp_valid = 4'h0;
        t_rsp_err   = 4'h0;
        t_rsp_rdata = '0;
    endtask

    // Reset lands while the transaction sits in WAIT; the late response must vanish.
    task automatic reset_in_wait();
        @(posedge clk); #1;
        idle_targets();
        req_valid = 1'b1; req_addr = 32'h1000_0000; req_we = 1'b0;
        req_wdata = 32'h5555_AAAA; req_be = 4'hF;
        @(negedge clk);
        check_eq("rw_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; t_req_ready = 4'b0010;
        @(negedge clk);
        check_eq("rw_issue", 32'(t_req_valid), 32'h2);
        @(posedge clk); #1;
        t_req_ready = 4'b0000;
        @(negedge clk);
        check_eq("rw_wait_tv", 32'(t_req_valid), 32'h0);
        check_eq("rw_wait_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rw_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        t_rsp_valid = 4'b0010; t_rsp_rdata[63:32] = 32'h0BAD_0BAD; t_rsp_err = 4'b0010;
        @(negedge clk);
        check_eq("rw_post_ready", 32'(req_ready), 32'd1);
        check_eq("rw_post_rsp", 32'(rsp_valid), 32'd0);
        check_eq("rw_post_tv", 32'(t_req_valid), 32'h0);
        check_eq("rw_post_addr", t_req_addr, 32'h0);
        check_eq("rw_post_wdata", t_req_wdata, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            idle_targets();
            @(negedge clk);
            check_eq("rw_late_rsp", 32'(rsp_valid), 32'd0);
            check_eq("rw_late_ready", 32'(req_ready), 32'd1);
        end
        $display("TXN reset-in-wait tgt=1 errors_so_far=%0d", n_errors);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_we    = 1'b0;
        req_be    = '0;
        idle_targets();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_t_req_valid", 32'(t_req_valid), 32'h0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_t_req_addr", t_req_addr, 32'h0);
        check_eq("rst_t_req_be", 32'(t_req_be), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rel_req_ready", 32'(req_ready), 32'd1);

        run_txn(32'h1000_0004, 1'b0, 32'h0, 4'hF, 1, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_txn(32'h2000_0000, 1'b1, 32'h1234_5678, 4'b0011, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
        run_txn(32'h3000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h1111_2222, 1'b0, 1'b0);
        run_txn(32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, 99, 32'h7777_7777, 1'b0, 1'b0);
        run_txn(32'h0000_0020, 1'b0, 32'h0, 4'hF, 0, 3, 32'hA5A5_0001, 1'b1, 1'b1);
        reset_in_wait();
        run_txn(32'hF000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h3333_4444, 1'b0, 1'b0);
        run_txn(32'hE000_0008, 1'b0, 32'h0, 4'hF, 2, 1, 32'h0C0F_FEE0, 1'b0, 1'b0);
        run_txn(32'h1000_0000, 1'b0, 32'h0, 4'hF, 9, 0, 32'h9999_0000, 1'b0, 1'b0);
        run_txn(32'h1000_0000, 1'b0, 32'h0, 4'hF, 7, 0, 32'h8888_0000, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] dt;
            logic        w;
            logic        e;
            logic [3:0]  b;
            int          rr;
            int          dd;
            a  = $urandom;
            wd = $urandom;
            dt = $urandom;
            w  = 1'($urandom_range(1, 0));
            e  = 1'($urandom_range(1, 0));
            b  = 4'($urandom_range(15, 0));
            rr = int'($urandom_range(9, 0));
            dd = ($urandom_range(7, 0) == 0) ? 99 : int'($urandom_range(9, 0));
            run_txn(a, w, wd, b, rr, dd, dt, e, 1'($urandom_range(1, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
